// File: rtl/sega_pad.sv
// Sega Mega Drive 3/6-button pad reader: drives SELECT, samples the six data pins per phase,
// publishes a frame-consistent 12-bit button word. Six-button support is enabled by SEGA_SIX_EN.
module sega_pad #(
    parameter int PHASE_CYC = 250,
    parameter int IDLE_CYC  = 50000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pin_d1,
    input  logic        pin_d2,
    input  logic        pin_d3,
    input  logic        pin_d4,
    input  logic        pin_d6,
    input  logic        pin_d9,
    output logic        pin_d7,
    output logic [11:0] joy,
    output logic        present,
    output logic        six,
    output logic        done
);

    // state  | meaning
    // S_IDLE | SELECT high, pad counter resets; lasts IDLE_CYC
    // S_PH0  | H1: dpad, B, C
    // S_PH1  | L1: A, Start, presence (d3/d4 low)
    // S_PH2-4| H2/L2/H3: no capture
    // S_PH5  | L3: six-button candidate (d1..d4 low)
    // S_PH6  | H4: X, Y, Z, Mode
    // S_PH7  | L4: publish frame
    typedef enum logic [3:0] {
        S_IDLE, S_PH0, S_PH1, S_PH2, S_PH3, S_PH4, S_PH5, S_PH6, S_PH7
    } state_e;

    localparam int MAX_CYC = (IDLE_CYC > PHASE_CYC) ? IDLE_CYC : PHASE_CYC;
    localparam int CW      = $clog2(MAX_CYC);
    localparam logic [CW-1:0] IDLE_LD  = CW'(IDLE_CYC - 1);
    localparam logic [CW-1:0] PHASE_LD = CW'(PHASE_CYC - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [5:0]    sync1_q;
    logic [5:0]    sync2_q;
    logic          pin_d7_q;
    logic [11:0]   joy_q;
    logic          present_q;
    logic          six_q;
    logic          done_q;
    logic [3:0]    sh_dir_q;
    logic          sh_b_q;
    logic          sh_c_q;
`ifdef SEGA_SIX_EN
    logic          sh_a_q;
    logic          sh_st_q;
    logic          sh_pres_q;
    logic          sh_cand_q;
    logic [3:0]    sh_ext_q;
`endif

    // {d9,d6,d4,d3,d2,d1}, 1 = pin driven low
    logic [5:0] smp;
    assign smp = sync2_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= IDLE_LD;
            sync1_q   <= '0;
            sync2_q   <= '0;
            pin_d7_q  <= 1'b1;
            joy_q     <= '0;
            present_q <= 1'b0;
            six_q     <= 1'b0;
            done_q    <= 1'b0;
            sh_dir_q  <= '0;
            sh_b_q    <= 1'b0;
            sh_c_q    <= 1'b0;
`ifdef SEGA_SIX_EN
            sh_a_q    <= 1'b0;
            sh_st_q   <= 1'b0;
            sh_pres_q <= 1'b0;
            sh_cand_q <= 1'b0;
            sh_ext_q  <= '0;
`endif
        end else begin
            sync1_q <= ~{pin_d9, pin_d6, pin_d4, pin_d3, pin_d2, pin_d1};
            sync2_q <= sync1_q;
            done_q  <= 1'b0;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end else begin
                // Phases alternate SELECT; idle entry/exit override below.
                cnt_q    <= PHASE_LD;
                pin_d7_q <= ~pin_d7_q;
                case (state_q)
                    S_IDLE: begin
                        state_q  <= S_PH0;
                        pin_d7_q <= 1'b1;
                    end
                    S_PH0: begin
                        sh_dir_q <= smp[3:0];
                        sh_b_q   <= smp[4];
                        sh_c_q   <= smp[5];
                        state_q  <= S_PH1;
                    end
                    S_PH1: begin
`ifdef SEGA_SIX_EN
                        sh_a_q    <= smp[4];
                        sh_st_q   <= smp[5];
                        sh_pres_q <= smp[2] & smp[3];
                        state_q   <= S_PH2;
`else
                        present_q <= smp[2] & smp[3];
                        joy_q     <= (smp[2] & smp[3]) ?
                                     {4'b0000, sh_dir_q, smp[5], sh_c_q, sh_b_q, smp[4]} : '0;
                        done_q    <= 1'b1;
                        state_q   <= S_IDLE;
                        cnt_q     <= IDLE_LD;
                        pin_d7_q  <= 1'b1;
`endif
                    end
`ifdef SEGA_SIX_EN
                    S_PH2: state_q <= S_PH3;
                    S_PH3: state_q <= S_PH4;
                    S_PH4: state_q <= S_PH5;
                    S_PH5: begin
                        sh_cand_q <= &smp[3:0];
                        state_q   <= S_PH6;
                    end
                    S_PH6: begin
                        sh_ext_q <= sh_cand_q ? {smp[3], smp[0], smp[1], smp[2]} : 4'b0000;
                        state_q  <= S_PH7;
                    end
                    S_PH7: begin
                        present_q <= sh_pres_q;
                        six_q     <= sh_pres_q & sh_cand_q;
                        joy_q     <= sh_pres_q ?
                                     {sh_ext_q, sh_dir_q, sh_st_q, sh_c_q, sh_b_q, sh_a_q} : '0;
                        done_q    <= 1'b1;
                        state_q   <= S_IDLE;
                        cnt_q     <= IDLE_LD;
                        pin_d7_q  <= 1'b1;
                    end
`endif
                    default: begin
                        state_q  <= S_IDLE;
                        cnt_q    <= IDLE_LD;
                        pin_d7_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign pin_d7  = pin_d7_q;
    assign joy     = joy_q;
    assign present = present_q;
    assign six     = six_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sega_pad.sv
// Bench for sega_pad: protocol-level pad model plus a sample-instant model of the expected outputs.
module tb_sega_pad;
    localparam int PC   = 4;
    localparam int IDLE = 20;
`ifdef SEGA_SIX_EN
    localparam int NPH = 8;
`else
    localparam int NPH = 2;
`endif
    localparam int ACT = NPH * PC;
    localparam int PER = IDLE + ACT;
    localparam logic [11:0] EXT_MASK = (NPH == 8) ? 12'hFFF : 12'h0FF;
    localparam logic SIX_OK = (NPH == 8);

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic pin_d1, pin_d2, pin_d3, pin_d4, pin_d6, pin_d9;
    logic pin_d7;
    logic [11:0] joy;
    logic present, six, done;

    int checks = 0;
    int errors = 0;

    sega_pad #(.PHASE_CYC(PC), .IDLE_CYC(IDLE)) dut (
        .clock(clock), .reset_n(reset_n),
        .pin_d1(pin_d1), .pin_d2(pin_d2), .pin_d3(pin_d3), .pin_d4(pin_d4),
        .pin_d6(pin_d6), .pin_d9(pin_d9), .pin_d7(pin_d7),
        .joy(joy), .present(present), .six(six), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pad model: 0 none, 1 three-button, 2 six-button; btn uses the joy bit layout.
    int          pad_kind = 1;
    logic [11:0] btn = '0;
    logic        glitch_d1 = 1'b0;
    int          lows = 0;
    int          hi_cnt = 0;
    logic        pad_rst = 1'b0;
    logic [5:0]  pd;

    always @(negedge pin_d7 or posedge pad_rst)
        if (pad_rst) lows <= 0;
        else         lows <= lows + 1;

    always @(posedge clock) begin
        hi_cnt  <= (pin_d7 === 1'b1) ? hi_cnt + 1 : 0;
        pad_rst <= (hi_cnt == 8);
    end

    always @* begin
        pd = 6'h3F;  // {d9,d6,d4,d3,d2,d1}
        if (pad_kind != 0) begin
            if (pin_d7 === 1'b1) begin
                pd[5] = ~btn[2];
                pd[4] = ~btn[1];
                if (pad_kind == 2 && lows == 3)
                    pd[3:0] = ~{btn[11], btn[8], btn[9], btn[10]};
                else
                    pd[3:0] = ~btn[7:4];
            end else begin
                pd[5] = ~btn[3];
                pd[4] = ~btn[0];
                if (pad_kind == 2 && lows == 3)      pd[3:0] = 4'b0000;
                else if (pad_kind == 2 && lows == 4) pd[3:0] = 4'b1111;
                else                                 pd[3:0] = {2'b00, ~btn[5], ~btn[4]};
            end
        end
        pin_d1 = pd[0] & ~glitch_d1;
        pin_d2 = pd[1];
        pin_d3 = pd[2];
        pin_d4 = pd[3];
        pin_d6 = pd[4];
        pin_d9 = pd[5];
    end

    // hist[j] = pin levels seen just before clock edge j
    logic [5:0] hist [8192];
    int cyc = 0;
    int r_edge = -1;

    always @(posedge clock) begin
        hist[cyc[12:0]] <= {pin_d9, pin_d6, pin_d4, pin_d3, pin_d2, pin_d1};
        if (!reset_n) r_edge <= cyc;
        cyc <= cyc + 1;
    end

    logic [11:0] exp_joy = '0;
    logic        exp_pres = 1'b0;
    logic        exp_six = 1'b0;

    // Phase p of a frame entered at edge f is sampled from pins two edges before its last edge.
    function automatic logic [5:0] pressed_at(input int f, input int p);
        int idx;
        idx = f + (p + 1) * PC - 2;
        return ~hist[idx[12:0]];
    endfunction

    task automatic model_frame(input int f);
        logic [5:0]  h0, h1, h5, h6;
        logic [11:0] w;
        logic        pres, cand;
        h0 = pressed_at(f, 0);
        h1 = pressed_at(f, 1);
        pres = h1[2] & h1[3];
        w = {4'b0000, h0[3], h0[2], h0[1], h0[0], h1[5], h0[5], h0[4], h1[4]};
        cand = 1'b0;
        if (NPH == 8) begin
            h5 = pressed_at(f, 5);
            h6 = pressed_at(f, 6);
            cand = &h5[3:0];
            if (cand) w[11:8] = {h6[3], h6[0], h6[1], h6[2]};
        end
        exp_pres = pres;
        exp_joy  = pres ? w : 12'h000;
        exp_six  = pres & cand;
    endtask

    always @(negedge clock) begin
        int k, n, pos;
        logic e_pin, e_done;
        if (r_edge >= 0) begin
            k = cyc - 1;
            n = k - r_edge;
            e_pin = 1'b1;
            e_done = 1'b0;
            if (n == 0) begin
                exp_joy = '0;
                exp_pres = 1'b0;
                exp_six = 1'b0;
            end else if (n >= IDLE) begin
                pos = (n - IDLE) % PER;
                e_done = (pos == ACT);
                e_pin = (pos >= ACT) || (((pos / PC) % 2) == 0);
                if (e_done) model_frame(k - ACT);
            end
            chk("sel", pin_d7, e_pin);
            chk("done", done, e_done);
            chk("joy", joy, exp_joy);
            chk("present", present, exp_pres);
            chk("six", six, exp_six);
        end
    end

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 4 * PER; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic first_frame();
        int fall, dn;
        fall = -1;
        dn = -1;
        for (int i = 1; i <= 4 * PER; i++) begin
            @(posedge clock); #1;
            if (fall < 0 && pin_d7 === 1'b0) begin
                fall = i;
                chk("pre_joy", joy, 12'h000);
                chk("pre_present", present, 1'b0);
            end
            if (done === 1'b1) begin
                dn = i;
                break;
            end
        end
        chk("first_fall", fall, 24);
        chk("first_done", dn, PER);
    endtask

    task automatic lit(input logic [11:0] ej, input logic ep, input logic es);
        chk("lit_joy", joy, ej);
        chk("lit_present", present, ep);
        chk("lit_six", six, es);
        chk("model_joy", exp_joy, ej);
    endtask

    task automatic frame_check(input logic [11:0] ej, input logic ep, input logic es);
        int n;
        wait_done(n);
        chk("period", n, PER);
        @(negedge clock); #1;
        lit(ej, ep, es);
    endtask

    initial begin
        int n;
        pad_kind = 1;
        btn = 12'h018;
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        first_frame();
        @(negedge clock); #1;
        lit(12'h018, 1'b1, 1'b0);
        frame_check(12'h018, 1'b1, 1'b0);

        pad_kind = 2;
        btn = 12'h901;
        frame_check(12'h901 & EXT_MASK, 1'b1, SIX_OK);
        btn = 12'h5A6;
        frame_check(12'h5A6 & EXT_MASK, 1'b1, SIX_OK);

        pad_kind = 1;
        btn = 12'h0C6;
        frame_check(12'h0C6, 1'b1, 1'b0);

        pad_kind = 0;
        btn = 12'hFFF;
        frame_check(12'h000, 1'b0, 1'b0);
        frame_check(12'h000, 1'b0, 1'b0);

        // Glitch d1 low on every clock except the ones that feed a sample.
        pad_kind = 1;
        btn = 12'h000;
        @(posedge clock); #1;
        for (int j = 0; j < PER - 2; j++) begin
            glitch_d1 = (((j + 2 - IDLE) % PC) != 2);
            @(posedge clock); #1;
        end
        glitch_d1 = 1'b0;
        wait_done(n);
        chk("glitch_done", n, 1);
        @(negedge clock); #1;
        lit(12'h000, 1'b1, 1'b0);
        chk("glitch_up", joy[4], 1'b0);

        btn = 12'h018;
        frame_check(12'h018, 1'b1, 1'b0);
        repeat (IDLE + 13) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("rst_sel", pin_d7, 1'b1);
        chk("rst_joy", joy, 12'h000);
        chk("rst_present", present, 1'b0);
        chk("rst_six", six, 1'b0);
        chk("rst_done", done, 1'b0);
        reset_n = 1'b1;
        first_frame();
        @(negedge clock); #1;
        lit(12'h018, 1'b1, 1'b0);

        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
